cc_writeback_unit: RTL and testbench

- Evicts one dirty 512-bit cache line to memory as a single 8-beat AXI write burst (AW, W, B channels).
- Sits between the cache controller's eviction path (line address and data read from the SRAM) and the memory AXI write channels.
- Serializer counterpart of the R-channel fill/deserializer path: a 64-bit beat stream, incrementing from offset 0, with no wrap.

---
 rtl/cc_writeback_unit.sv | 123 ++++++++++++
 tb/tb_cc_writeback_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cc_writeback_unit.sv
// Dirty-line writeback engine: serializes one latched cache line into a single
// INCR AXI write burst and reports the write response back to the cache controller.
module cc_writeback_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_req_valid_i,
  output logic                      wb_req_ready_o,
  input  logic [ADDR_W-1:0]         wb_addr_i,
  input  logic [DATA_W*BEATS-1:0]   wb_data_i,
  output logic                      wb_busy_o,
  output logic                      wb_done_o,
  output logic                      wb_err_o,
  output logic [ADDR_W-1:0]         mem_awaddr_o,
  output logic [3:0]                mem_awlen_o,
  output logic [2:0]                mem_awsize_o,
  output logic [1:0]                mem_awburst_o,
  output logic                      mem_awvalid_o,
  input  logic                      mem_awready_i,
  output logic [DATA_W-1:0]         mem_wdata_o,
  output logic [DATA_W/8-1:0]       mem_wstrb_o,
  output logic                      mem_wlast_o,
  output logic                      mem_wvalid_o,
  input  logic                      mem_wready_i,
  input  logic [1:0]                mem_bresp_i,
  input  logic                      mem_bvalid_i,
  output logic                      mem_bready_o
);

  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(DATA_W / 8 * BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W,
    B
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  logic [DATA_W*BEATS-1:0]   line_q;
  logic [ADDR_W-1:0]         addr_q;
  logic                      done_q, err_q;
  logic                      accept, beat_fire, resp_fire;
  logic                      unused_bits;

  // Line-offset address bits and the OKAY/EXOKAY distinction are irrelevant here.
  assign unused_bits = ^{wb_addr_i[OFF_W-1:0], mem_bresp_i[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    wb_req_ready_o = 1'b0;
    mem_awvalid_o  = 1'b0;
    mem_wvalid_o   = 1'b0;
    mem_bready_o   = 1'b0;
    case (state_q)
      IDLE: begin
        wb_req_ready_o = 1'b1;
        if (wb_req_valid_i) state_d = AW;
      end
      AW: begin
        mem_awvalid_o = 1'b1;
        if (mem_awready_i) state_d = W;
      end
      W: begin
        mem_wvalid_o = 1'b1;
        if (mem_wready_i && cnt_q == LAST_BEAT) state_d = B;
      end
      B: begin
        mem_bready_o = 1'b1;
        if (mem_bvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = wb_req_valid_i && wb_req_ready_o;
  assign beat_fire = mem_wvalid_o && mem_wready_i;
  assign resp_fire = mem_bready_o && mem_bvalid_i;

  // The counter wraps to zero naturally after the last beat of the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      line_q <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= resp_fire;
      err_q  <= resp_fire && mem_bresp_i[1];
      if (accept) begin
        addr_q <= {wb_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        line_q <= wb_data_i;
        cnt_q  <= '0;
      end else if (beat_fire) begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign wb_busy_o     = (state_q != IDLE);
  assign wb_done_o     = done_q;
  assign wb_err_o      = err_q;
  assign mem_awaddr_o  = addr_q;
  assign mem_awlen_o   = 4'(BEATS - 1);
  assign mem_awsize_o  = 3'($clog2(DATA_W / 8));
  assign mem_awburst_o = 2'b01;
  assign mem_wdata_o   = line_q[DATA_W*cnt_q +: DATA_W];
  assign mem_wstrb_o   = {(DATA_W/8){1'b1}};
  assign mem_wlast_o   = mem_wvalid_o && (cnt_q == LAST_BEAT);

endmodule

// File: tb/tb_cc_writeback_unit.sv
// Directed bench for cc_writeback_unit: drives eviction requests and AXI ready
// patterns, checking every handshake-visible output against hand-computed values.
module tb_cc_writeback_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wb_req_valid_i = 1'b0;
  logic         wb_req_ready_o;
  logic [31:0]  wb_addr_i = '0;
  logic [511:0] wb_data_i = '0;
  logic         wb_busy_o, wb_done_o, wb_err_o;
  logic [31:0]  mem_awaddr_o;
  logic [3:0]   mem_awlen_o;
  logic [2:0]   mem_awsize_o;
  logic [1:0]   mem_awburst_o;
  logic         mem_awvalid_o;
  logic         mem_awready_i = 1'b0;
  logic [63:0]  mem_wdata_o;
  logic [7:0]   mem_wstrb_o;
  logic         mem_wlast_o, mem_wvalid_o;
  logic         mem_wready_i = 1'b0;
  logic [1:0]   mem_bresp_i = 2'b00;
  logic         mem_bvalid_i = 1'b0;
  logic         mem_bready_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cc_writeback_unit dut (
    .clk(clk), .rst(rst),
    .wb_req_valid_i(wb_req_valid_i), .wb_req_ready_o(wb_req_ready_o),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .wb_busy_o(wb_busy_o), .wb_done_o(wb_done_o), .wb_err_o(wb_err_o),
    .mem_awaddr_o(mem_awaddr_o), .mem_awlen_o(mem_awlen_o),
    .mem_awsize_o(mem_awsize_o), .mem_awburst_o(mem_awburst_o),
    .mem_awvalid_o(mem_awvalid_o), .mem_awready_i(mem_awready_i),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_wlast_o(mem_wlast_o), .mem_wvalid_o(mem_wvalid_o),
    .mem_wready_i(mem_wready_i),
    .mem_bresp_i(mem_bresp_i), .mem_bvalid_i(mem_bvalid_i),
    .mem_bready_o(mem_bready_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [511:0] lineOf(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[64*k +: 64] = base * 64'(k + 1);
    return l;
  endfunction

  // One complete burst. w_mode 0: wready always 1; 1: wready pattern 1,0,0 repeating.
  // chain: hold the next request valid throughout and let it be taken at the done cycle.
  task automatic applyStimulus(input bit skip_req, input logic [31:0] addr, input logic [63:0] base,
                               input int aw_stall, input int w_mode, input logic [1:0] bresp,
                               input bit chain, input logic [31:0] naddr, input logic [63:0] nbase,
                               input int exp_lat);
    int start;
    bit hs;
    bit aw_done;
    int beat;
    start = cyc;
    if (!skip_req) begin
      wb_req_valid_i = 1'b1;
      wb_addr_i      = addr;
      wb_data_i      = lineOf(base);
      checkOutput("req_ready_idle", wb_req_ready_o, 1);
      tick();
    end
    wb_req_valid_i = chain;
    wb_addr_i      = chain ? naddr : $urandom;
    wb_data_i      = chain ? lineOf(nbase) : {16{$urandom}};

    aw_done = 0;
    for (int i = 0; i < 50 && !aw_done; i++) begin
      mem_awready_i = (i >= aw_stall);
      checkOutput("awvalid", mem_awvalid_o, 1);
      checkOutput("awaddr", mem_awaddr_o, {addr[31:6], 6'b0});
      checkOutput("wvalid_before_aw", mem_wvalid_o, 0);
      checkOutput("busy_aw", wb_busy_o, 1);
      if (chain) checkOutput("req_ready_busy", wb_req_ready_o, 0);
      hs = mem_awready_i;
      tick();
      if (hs) aw_done = 1;
    end
    mem_awready_i = 1'b0;
    if (!aw_done) checkOutput("aw_timeout", 0, 1);

    beat = 0;
    for (int i = 0; i < 100 && beat < 8; i++) begin
      mem_wready_i = (w_mode == 0) ? 1'b1 : (i % 3 == 0);
      checkOutput("wvalid", mem_wvalid_o, 1);
      checkOutput("awvalid_in_w", mem_awvalid_o, 0);
      checkOutput($sformatf("wdata_beat%0d", beat), mem_wdata_o, base * 64'(beat + 1));
      checkOutput($sformatf("wlast_beat%0d", beat), mem_wlast_o, (beat == 7));
      if (chain) checkOutput("req_ready_busy", wb_req_ready_o, 0);
      hs = mem_wready_i;
      tick();
      if (hs) beat++;
    end
    mem_wready_i = 1'b0;
    checkOutput("w_beats", beat, 8);

    checkOutput("bready", mem_bready_o, 1);
    checkOutput("wvalid_in_b", mem_wvalid_o, 0);
    checkOutput("done_early", wb_done_o, 0);
    mem_bvalid_i = 1'b1;
    mem_bresp_i  = bresp;
    tick();
    mem_bvalid_i = 1'b0;
    mem_bresp_i  = 2'b00;
    checkOutput("done_pulse", wb_done_o, 1);
    checkOutput("err", wb_err_o, bresp[1]);
    checkOutput("busy_done", wb_busy_o, 0);
    checkOutput("req_ready_done", wb_req_ready_o, 1);
    checkOutput("bready_done", mem_bready_o, 0);
    if (exp_lat >= 0) checkOutput("done_latency", cyc - start, exp_lat);
    tick();
    wb_req_valid_i = 1'b0;
    checkOutput("done_one_cycle", wb_done_o, 0);
    checkOutput("err_clear", wb_err_o, 0);
    checkOutput("busy_after", wb_busy_o, chain);
  endtask

  initial begin
    #12;
    checkOutput("rst_ready", wb_req_ready_o, 1);
    checkOutput("rst_busy", wb_busy_o, 0);
    checkOutput("rst_awvalid", mem_awvalid_o, 0);
    checkOutput("rst_wvalid", mem_wvalid_o, 0);
    checkOutput("rst_wlast", mem_wlast_o, 0);
    checkOutput("rst_bready", mem_bready_o, 0);
    checkOutput("rst_done", wb_done_o, 0);
    checkOutput("rst_err", wb_err_o, 0);
    checkOutput("rst_awaddr", mem_awaddr_o, 0);
    rst = 1'b0;
    tick();

    checkOutput("awlen", mem_awlen_o, 7);
    checkOutput("awsize", mem_awsize_o, 3'b011);
    checkOutput("awburst", mem_awburst_o, 2'b01);
    checkOutput("wstrb", mem_wstrb_o, 8'hFF);

    // Stray write response while idle must be ignored.
    mem_bvalid_i = 1'b1;
    mem_bresp_i  = 2'b10;
    checkOutput("bready_idle", mem_bready_o, 0);
    tick();
    mem_bvalid_i = 1'b0;
    mem_bresp_i  = 2'b00;
    tick();
    checkOutput("stray_b_done", wb_done_o, 0);
    checkOutput("stray_b_busy", wb_busy_o, 0);

    $display("[TB] single eviction");
    applyStimulus(0, 32'h0001_2345, 64'h1111_1111_1111_1111, 0, 0, 2'b00, 0, 0, 0, 11);

    $display("[TB] AW backpressure");
    applyStimulus(0, 32'hDEAD_BEFF, 64'h0102_0304_0506_0708, 3, 0, 2'b00, 0, 0, 0, 14);

    $display("[TB] W backpressure");
    applyStimulus(0, 32'h0000_0040, 64'h0F0F_0000_1234_0001, 0, 1, 2'b00, 0, 0, 0, -1);

    $display("[TB] error responses");
    applyStimulus(0, 32'h8000_0000, 64'h0000_0000_0000_0005, 0, 0, 2'b10, 0, 0, 0, 11);
    applyStimulus(0, 32'h8000_0080, 64'h0000_0000_0000_0007, 0, 0, 2'b00, 0, 0, 0, 11);
    applyStimulus(0, 32'h8000_00C0, 64'h0000_0000_0000_0009, 0, 0, 2'b11, 0, 0, 0, 11);

    $display("[TB] back-to-back");
    applyStimulus(0, 32'h0000_1000, 64'h2222_0000_0000_0001, 0, 0, 2'b00, 1,
                  32'h0000_2FFF, 64'h3333_0000_0000_0003, 11);
    applyStimulus(1, 32'h0000_2FFF, 64'h3333_0000_0000_0003, 0, 0, 2'b00, 0, 0, 0, -1);

    $display("[TB] reset mid-burst");
    wb_req_valid_i = 1'b1;
    wb_addr_i      = 32'h0004_0000;
    wb_data_i      = lineOf(64'h0000_00AA_0000_0001);
    tick();
    wb_req_valid_i = 1'b0;
    mem_awready_i  = 1'b1;
    tick();
    mem_awready_i  = 1'b0;
    mem_wready_i   = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("pre_rst_wvalid", mem_wvalid_o, 1);
    checkOutput("pre_rst_wdata", mem_wdata_o, 64'h0000_00AA_0000_0001 * 64'd4);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_wvalid", mem_wvalid_o, 0);
    checkOutput("rst_mid_wlast", mem_wlast_o, 0);
    checkOutput("rst_mid_busy", wb_busy_o, 0);
    checkOutput("rst_mid_ready", wb_req_ready_o, 1);
    mem_wready_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_mid_no_done", wb_done_o, 0);
    checkOutput("rst_mid_idle", wb_busy_o, 0);
    applyStimulus(0, 32'h0004_0000, 64'h0000_00BB_0000_0002, 0, 0, 2'b00, 0, 0, 0, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=%0d expected=finished", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
